// File: rtl/multicycle_control.sv
// multicycle_control
//   Main sequencing FSM for the multicycle RV32I datapath. It steps each
//   instruction through fetch, decode, execute, memory and writeback. It drives
//   the datapath mux selects, the write strobes and ALUOp for the ALU control
//   decoder, and it counts retired instructions.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   opcode_i       instr[6:0] from the instruction register (valid from DECODE)
//   mem_ready_i    memory accepted the write or returned read data this cycle
//   alu_op_o       00 add, 01 subtract (branch compare), 10 decode funct3/funct7
//   alu_src_a_o    00 PC, 01 old PC, 10 rs1
//   alu_src_b_o    00 rs2, 01 immediate, 10 constant 4
//   result_src_o   00 ALUOut, 01 memory data register, 10 ALU result
//   adr_src_o      memory address: 0 PC, 1 result bus
//   mem_read_o / mem_write_o               memory request strobes
//   ir_write_o / pc_write_o / reg_write_o  register write enables
//   branch_o       the datapath ANDs this with the ALU zero flag
//   illegal_o      one-cycle pulse in DECODE on an unsupported opcode
//   state_o        current state, for debug
//   instret_o      retired-instruction counter, wraps modulo 2^CNT_W
//
// state  | code | meaning
// FETCH  | 0    | read instruction at PC, PC += 4 on mem_ready
// DECODE | 1    | read registers, compute branch target, dispatch on opcode
// MEMADR | 2    | rs1 + imm address for lw/sw
// MEMRD  | 3    | load request, wait for mem_ready
// MEMWB  | 4    | write load data to rd
// MEMWR  | 5    | store request, wait for mem_ready
// EXECR  | 6    | R-type ALU operation
// EXECI  | 7    | I-type ALU operation (add)
// ALUWB  | 8    | write ALU result to rd
// BEQ    | 9    | compare rs1/rs2, conditional PC write
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       result_src_o,
    output logic             adr_src_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic             branch_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    logic [1:0] alu_op_c, alu_src_a_c, alu_src_b_c, result_src_c;
    logic       adr_src_c, mem_read_c, mem_write_c, ir_write_c, pc_write_c;
    logic       reg_write_c, branch_c, illegal_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        retire       = 1'b0;
        alu_op_c     = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        result_src_c = 2'b00;
        adr_src_c    = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        branch_c     = 1'b0;
        illegal_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c   = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = mem_ready_i;
                pc_write_c   = mem_ready_i;
                state_d      = mem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                adr_src_c  = 1'b1;
                state_d    = mem_ready_i ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                retire      = mem_ready_i;
                state_d     = mem_ready_i ? S_FETCH : S_MEMWR;
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                branch_c    = 1'b1;
                retire      = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign instret_d = instret_q + CNT_W'(retire);

    // The state register already resets asynchronously to FETCH, but FETCH
    // itself drives a read request. Gating with rst_ni makes every strobe and
    // select drop the moment reset asserts, not at the next clock edge.
    assign alu_op_o     = rst_ni ? alu_op_c     : 2'b00;
    assign alu_src_a_o  = rst_ni ? alu_src_a_c  : 2'b00;
    assign alu_src_b_o  = rst_ni ? alu_src_b_c  : 2'b00;
    assign result_src_o = rst_ni ? result_src_c : 2'b00;
    assign adr_src_o    = rst_ni & adr_src_c;
    assign mem_read_o   = rst_ni & mem_read_c;
    assign mem_write_o  = rst_ni & mem_write_c;
    assign ir_write_o   = rst_ni & ir_write_c;
    assign pc_write_o   = rst_ni & pc_write_c;
    assign reg_write_o  = rst_ni & reg_write_c;
    assign branch_o     = rst_ni & branch_c;
    assign illegal_o    = rst_ni & illegal_c;

    assign state_o   = state_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. A 32-bit and a 3-bit counter instance share
// the same stimulus. The expected state sequence for each instruction is
// produced from its class and wait counts, and the expected outputs come from
// the per-state output table.
module tb_multicycle_control;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;

    logic [1:0]  alu_op, src_a, src_b, res_src;
    logic        adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, branch, illegal;
    logic [3:0]  state;
    logic [31:0] instret;

    logic [1:0]  alu_op3, src_a3, src_b3, res_src3;
    logic        adr_src3, mem_read3, mem_write3, ir_write3, pc_write3, reg_write3, branch3, illegal3;
    logic [3:0]  state3;
    logic [2:0]  instret3;

    logic [15:0] outs;
    assign outs = {alu_op, src_a, src_b, res_src, adr_src, mem_read, mem_write,
                   ir_write, pc_write, reg_write, branch, illegal};

    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned model_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .alu_op_o(alu_op), .alu_src_a_o(src_a), .alu_src_b_o(src_b), .result_src_o(res_src),
        .adr_src_o(adr_src), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_write_o(reg_write),
        .branch_o(branch), .illegal_o(illegal), .state_o(state), .instret_o(instret)
    );

    multicycle_control #(.CNT_W(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .alu_op_o(alu_op3), .alu_src_a_o(src_a3), .alu_src_b_o(src_b3), .result_src_o(res_src3),
        .adr_src_o(adr_src3), .mem_read_o(mem_read3), .mem_write_o(mem_write3),
        .ir_write_o(ir_write3), .pc_write_o(pc_write3), .reg_write_o(reg_write3),
        .branch_o(branch3), .illegal_o(illegal3), .state_o(state3), .instret_o(instret3)
    );

    // 0 lw, 1 sw, 2 R-type, 3 I-type, 4 beq, 5 illegal
    function automatic int cls(input logic [6:0] op);
        case (op)
            OP_LW:   return 0;
            OP_SW:   return 1;
            OP_R:    return 2;
            OP_I:    return 3;
            OP_BEQ:  return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input int s, input logic mr, input logic [6:0] op);
        logic [1:0] aop, sa, sb, rs;
        logic adr, rd, wr, ir, pc, rw, br, ill;
        {aop, sa, sb, rs} = 8'd0;
        {adr, rd, wr, ir, pc, rw, br, ill} = 8'd0;
        case (s)
            0: begin rd = 1; sb = 2'b10; rs = 2'b10; ir = mr; pc = mr; end
            1: begin sa = 2'b01; sb = 2'b01; ill = (cls(op) == 5); end
            2: begin sa = 2'b10; sb = 2'b01; end
            3: begin rd = 1; adr = 1; end
            4: begin rs = 2'b01; rw = 1; end
            5: begin wr = 1; adr = 1; end
            6: begin sa = 2'b10; aop = 2'b10; end
            7: begin sa = 2'b10; sb = 2'b01; end
            8: begin rw = 1; end
            9: begin sa = 2'b10; aop = 2'b01; br = 1; end
            default: ;
        endcase
        return {aop, sa, sb, rs, adr, rd, wr, ir, pc, rw, br, ill};
    endfunction

    typedef struct {
        int   s;
        logic mr;
    } step_t;

    // Run one instruction from FETCH, fw cycles of FETCH wait and mw cycles of
    // memory wait, checking every cycle.
    task automatic do_instr(input logic [6:0] op, input int fw, input int mw);
        step_t q[$];
        int    c;
        c = cls(op);
        for (int i = 0; i < fw; i++) q.push_back('{0, 1'b0});
        q.push_back('{0, 1'b1});
        q.push_back('{1, 1'($urandom_range(0, 1))});
        case (c)
            0: begin
                q.push_back('{2, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mw; i++) q.push_back('{3, 1'b0});
                q.push_back('{3, 1'b1});
                q.push_back('{4, 1'($urandom_range(0, 1))});
            end
            1: begin
                q.push_back('{2, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mw; i++) q.push_back('{5, 1'b0});
                q.push_back('{5, 1'b1});
            end
            2: begin
                q.push_back('{6, 1'($urandom_range(0, 1))});
                q.push_back('{8, 1'($urandom_range(0, 1))});
            end
            3: begin
                q.push_back('{7, 1'($urandom_range(0, 1))});
                q.push_back('{8, 1'($urandom_range(0, 1))});
            end
            4: q.push_back('{9, 1'($urandom_range(0, 1))});
            default: ;
        endcase
        foreach (q[i]) begin
            @(negedge clk);
            mem_ready = q[i].mr;
            opcode = (q[i].s == 0) ? 7'($urandom) : op;
            #1;
            n_checks++;
            if (state !== 4'(q[i].s))
                $display("FAIL state op=%b step=%0d got=%0d exp=%0d", op, i, state, q[i].s);
            else n_pass++;
            n_checks++;
            if (outs !== exp_out(q[i].s, q[i].mr, opcode))
                $display("FAIL outputs op=%b step=%0d got=%h exp=%h", op, i, outs,
                         exp_out(q[i].s, q[i].mr, opcode));
            else n_pass++;
            n_checks++;
            if (instret !== model_cnt)
                $display("FAIL instret op=%b step=%0d got=%0d exp=%0d", op, i, instret, model_cnt);
            else n_pass++;
            n_checks++;
            if (instret3 !== 3'(model_cnt))
                $display("FAIL instret3 op=%b step=%0d got=%0d exp=%0d", op, i, instret3, 3'(model_cnt));
            else n_pass++;
        end
        if (c != 5) model_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if ({state, outs, instret, instret3} !== '0)
                $display("FAIL reset_hold st=%0d outs=%h cnt=%0d cnt3=%0d exp=all zero",
                         state, outs, instret, instret3);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0 || outs !== exp_out(0, 1'b0, opcode))
            $display("FAIL reset_release st=%0d outs=%h exp st=0 outs=%h", state, outs, exp_out(0, 1'b0, opcode));
        else n_pass++;
    endtask

    task automatic test_rtype();
        do_instr(OP_R, 0, 0);
    endtask

    task automatic test_lw_wait();
        do_instr(OP_LW, 0, 3);
    endtask

    task automatic test_back_to_back();
        do_instr(OP_BEQ, 0, 0);
        do_instr(OP_SW, 0, 0);
        do_instr(OP_I, 1, 0);
    endtask

    task automatic test_illegal();
        do_instr(7'b1111111, 0, 0);
        do_instr(7'b0000000, 2, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) do_instr(OP_R, 0, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        logic [6:0] op;
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, 7'd0};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 5)];
            if (op == 7'd0) op = 7'($urandom);
            do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); mem_ready = 1'b1; opcode = 7'($urandom);
        @(negedge clk); mem_ready = 1'b0; opcode = OP_SW;
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd5 || mem_write !== 1'b1)
            $display("FAIL memwr_reach st=%0d mem_write=%b exp st=5 mem_write=1", state, mem_write);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({state, outs, instret, instret3} !== '0)
            $display("FAIL reset_mid st=%0d outs=%h cnt=%0d cnt3=%0d exp=all zero",
                     state, outs, instret, instret3);
        else n_pass++;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({state, outs, instret} !== '0)
            $display("FAIL reset_mid_hold st=%0d outs=%h cnt=%0d exp=all zero", state, outs, instret);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        model_cnt = 0;
        #1;
        n_checks++;
        if (state !== 4'd0 || mem_read !== 1'b1 || instret !== 32'd0)
            $display("FAIL reset_mid_release st=%0d mem_read=%b cnt=%0d exp st=0 mem_read=1 cnt=0",
                     state, mem_read, instret);
        else n_pass++;
        do_instr(OP_R, 0, 0);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_illegal();
        test_wrap();
        test_random();
        test_reset_mid();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0 || instret !== model_cnt)
            $display("FAIL final st=%0d cnt=%0d exp st=0 cnt=%0d", state, instret, model_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I datapath. It sits directly upstream of the ALU control decoder: it sequences fetch, decode, execute, memory and writeback, and drives `ALUOp` into that decoder. It also drives all datapath mux selects and write strobes, handshakes with instruction/data memory through `mem_ready`, and counts retired instructions.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: `instr[6:0]` from the instruction register; valid from DECODE onward.
- `mem_ready` in 1: memory accepted the write or returned read data this cycle.
- `ALUOp` out 2: to the ALU control decoder. 00 = add, 01 = subtract (branch compare), 10 = decode from funct3/funct7.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = rs1 data.
- `alu_src_b` out 2: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- `result_src` out 2: 00 = ALUOut register, 01 = memory data register, 10 = ALU result.
- `adr_src` out 1: 0 = PC, 1 = result bus.
- `mem_read`, `mem_write` out 1 each: memory request strobes.
- `ir_write`, `pc_write`, `reg_write` out 1 each: register write enables.
- `branch` out 1: the datapath forms `pc_write_cond = branch & zero`.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug.
- `instret` out CNT_W: count of retired instructions.

## Operation
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9. Codes 10–15 are unreachable; if entered, go to FETCH with all strobes 0.
- Outputs are Moore-decoded from `state`, except `ir_write`, `pc_write` and `illegal` as noted. Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `ALUOp`=00, `result_src`=10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; on `mem_ready`=1 go to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `ALUOp`=00 (computes the branch target). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 (R-type) → EXECR
  - 0010011 (I-type ALU) → EXECI
  - 1100011 (beq) → BEQ
  - any other opcode → FETCH, with `illegal`=1 for this cycle.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `ALUOp`=00. Go to MEMRD if opcode is lw, else MEMWR.
- MEMRD: `mem_read`=1, `adr_src`=1, `result_src`=00. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Go to FETCH.
- MEMWR: `mem_write`=1, `adr_src`=1, `result_src`=00. Wait for `mem_ready`, then go to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `ALUOp`=10. Go to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `ALUOp`=00 (add only). Go to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Go to FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `ALUOp`=01, `result_src`=00, `branch`=1. Go to FETCH.
- `instret` increments by 1, modulo 2^CNT_W, on each retirement. Retirement is the edge leaving MEMWB, ALUWB or BEQ, or the edge leaving MEMWR with `mem_ready`=1. Illegal opcodes do not retire.

## Timing
- While `rst_n`=0: `state`=FETCH, `instret`=0, and every strobe (`mem_read`, `mem_write`, `ir_write`, `pc_write`, `reg_write`, `branch`, `illegal`) is 0. All selects are 0.
- First `mem_read` is seen in the first cycle after `rst_n` deasserts.
- Latency with `mem_ready` high in the same cycle as the request: lw 5 cycles, sw 4, R-type 4, I-type 4, beq 3, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Request strobes and address stay stable throughout the wait.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: the transaction is abandoned at once. Strobes drop asynchronously; no retire and no `reg_write` occur.

## Test plan
- Reset, then release with `mem_ready`=1 → state sequence FETCH, DECODE; `mem_read`=1 in cycle 1; `instret`=0 throughout reset.
- R-type (0110011) with `mem_ready`=1 → states 0,1,6,8,0; `ALUOp`=10 in EXECR; `reg_write`=1 only in ALUWB; `instret` 0→1.
- lw with `mem_ready` held low 3 cycles in MEMRD → MEMRD held 4 cycles with `mem_read`=1, `adr_src`=1; MEMWB gives `result_src`=01, `reg_write`=1; total 8 cycles.
- beq then sw back-to-back → BEQ asserts `ALUOp`=01, `branch`=1 for one cycle; sw asserts `mem_write` only in MEMWR and no `reg_write`; `instret` +2.
- Opcode 1111111 → `illegal`=1 for exactly one cycle in DECODE, then FETCH; `instret` unchanged.
- `CNT_W`=3, 9 R-types → `instret` wraps 7→0→1. Separately, `rst_n` pulsed low in MEMWR → `mem_write` drops immediately, state=0, `instret`=0.
